// File: rtl/mul_pkg.sv
// Shared definitions for the multiply scheduler: operation codes, FSM states
// and the default operand width / iteration count.
package mul_pkg;

  localparam int DEFAULT_WIDTH = 32;
  // One shift-add step per multiplier bit gives the full-width product.
  localparam int DEFAULT_ITER  = DEFAULT_WIDTH;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MADDU = 2'b01,
    OP_CLR   = 2'b10
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // The unused code 2'b11 behaves exactly like a clear.
  function automatic op_e op_decode(input logic [1:0] code);
    case (code)
      2'b00:   return OP_MULTU;
      2'b01:   return OP_MADDU;
      default: return OP_CLR;
    endcase
  endfunction

endpackage

// File: rtl/mul_sched_if.sv
// Bundle of the two requester channels, the response channel and busy.
//   master : requester side (drives valid/op/a/b, observes ready/rsp/busy)
//   slave  : scheduler side (the mul_sched module)
interface mul_sched_if
  import mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic               req0_valid;
  logic               req0_ready;
  logic [1:0]         req0_op;
  logic [WIDTH-1:0]   req0_a;
  logic [WIDTH-1:0]   req0_b;
  logic               req1_valid;
  logic               req1_ready;
  logic [1:0]         req1_op;
  logic [WIDTH-1:0]   req1_a;
  logic [WIDTH-1:0]   req1_b;
  logic               rsp_valid;
  logic               rsp_id;
  logic [2*WIDTH-1:0] rsp_hilo;
  logic               busy;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_hilo, busy
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_hilo, busy
  );
endinterface

// File: rtl/mul_core.sv
// Iterative unsigned shift-add multiplier, one step per clock.
//   clk, rst : clock, synchronous active-high reset (aborts a running multiply)
//   start    : load a/b and begin ITER steps from a zero partial product
//   a, b     : multiplicand / multiplier
//   product  : running partial product; final once the last step has run
//   done     : high during the last step (the product is final the next cycle)
module mul_core
  import mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int ITER  = WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               done
);
  localparam int CW = $clog2(ITER + 1);

  logic [2*WIDTH-1:0] mcnd_q, mcnd_d;
  logic [2*WIDTH-1:0] part_q, part_d;
  logic [WIDTH-1:0]   mpr_q,  mpr_d;
  logic [CW-1:0]      count_q, count_d;

  // No early exit on zero operands: a nonzero count always runs to 1.
  always_comb begin
    mcnd_d  = mcnd_q;
    part_d  = part_q;
    mpr_d   = mpr_q;
    count_d = count_q;
    if (start) begin
      mcnd_d  = {{WIDTH{1'b0}}, a};
      mpr_d   = b;
      part_d  = '0;
      count_d = CW'(ITER);
    end else if (count_q != '0) begin
      if (mpr_q[0]) part_d = part_q + mcnd_q;
      mcnd_d  = mcnd_q << 1;
      mpr_d   = mpr_q >> 1;
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcnd_q  <= '0;
      part_q  <= '0;
      mpr_q   <= '0;
      count_q <= '0;
    end else begin
      mcnd_q  <= mcnd_d;
      part_q  <= part_d;
      mpr_q   <= mpr_d;
      count_q <= count_d;
    end
  end

  assign product = part_q;
  assign done    = (count_q == CW'(1));

endmodule

// File: rtl/mul_sched.sv
// Two-requester multiply/accumulate scheduler. Arbitrates round-robin between
// the requesters, runs one operation at a time on mul_core, and keeps one
// 2*WIDTH HI/LO accumulator per requester.
//   clk, rst : clock, synchronous active-high reset
//   bus      : requester channels (valid/ready/op/a/b), response channel
//              (rsp_valid/rsp_id/rsp_hilo) and busy
module mul_sched
  import mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int ITER  = WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  mul_sched_if.slave  bus
);
  logic [1:0]         valid;
  logic [1:0]         ready;
  logic [1:0]         op_arr [2];
  logic [WIDTH-1:0]   a_arr  [2];
  logic [WIDTH-1:0]   b_arr  [2];

  assign valid     = {bus.req1_valid, bus.req0_valid};
  assign op_arr[0] = bus.req0_op;
  assign op_arr[1] = bus.req1_op;
  assign a_arr[0]  = bus.req0_a;
  assign a_arr[1]  = bus.req1_a;
  assign b_arr[0]  = bus.req0_b;
  assign b_arr[1]  = bus.req1_b;

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic               id_q, id_d;
  logic               last_q, last_d;
  logic [2*WIDTH-1:0] acc_q [2];

  logic               grant;
  logic               accept;
  logic               core_done;
  logic [2*WIDTH-1:0] core_prod;
  logic [2*WIDTH-1:0] new_val;

  // Round-robin: on contention the requester not granted last time wins.
  always_comb begin
    grant = 1'b0;
    if (valid == 2'b11) grant = ~last_q;
    else if (valid[1])  grant = 1'b1;
  end

  assign accept = (state_q == ST_IDLE) && (valid != 2'b00);

  for (genvar gi = 0; gi < 2; gi++) begin : g_ready
    assign ready[gi] = (state_q == ST_IDLE) && valid[gi] && (grant == 1'(gi));
  end

  assign bus.req0_ready = ready[0];
  assign bus.req1_ready = ready[1];

  mul_core #(.WIDTH(WIDTH), .ITER(ITER)) u_core (
    .clk     (clk),
    .rst     (rst),
    .start   (accept),
    .a       (a_arr[grant]),
    .b       (b_arr[grant]),
    .product (core_prod),
    .done    (core_done)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    id_d    = id_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          id_d    = grant;
          last_d  = grant;
          op_d    = op_decode(op_arr[grant]);
          state_d = (op_d == OP_CLR) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN:  if (core_done) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Value written to the owner's accumulator and shown on rsp_hilo in DONE.
  always_comb begin
    case (op_q)
      OP_MULTU: new_val = core_prod;
      OP_MADDU: new_val = acc_q[id_q] + core_prod;
      default:  new_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_CLR;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
      for (int i = 0; i < 2; i++) acc_q[i] <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      id_q    <= id_d;
      last_q  <= last_d;
      if (state_q == ST_DONE) acc_q[id_q] <= new_val;
    end
  end

  assign bus.rsp_valid = (state_q == ST_DONE);
  assign bus.rsp_id    = (state_q == ST_DONE) ? id_q : 1'b0;
  assign bus.rsp_hilo  = (state_q == ST_DONE) ? new_val : '0;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: doc/mul_sched.md
MUL_SCHED -- requirements
Module: mul_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits.
REQ-002 SHALL have parameter ITER, default WIDTH, number of shift-add iterations per multiply.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports reqN_valid, input, 1, for N=0,1: requester N presents an operation.
REQ-006 SHALL have ports reqN_ready, output, 1: scheduler accepts requester N's operation this cycle.
REQ-007 SHALL have ports reqN_op, input, 2: operation code.
  - 00 MULTU
  - 01 MADDU
  - 10 CLR
  - 11 reserved, treated as CLR
REQ-008 SHALL have ports reqN_a and reqN_b, input, WIDTH each: unsigned operands.
REQ-009 SHALL have port rsp_valid, output, 1: one-cycle completion pulse.
REQ-010 SHALL have port rsp_id, output, 1: requester that owns the completed operation.
REQ-011 SHALL have port rsp_hilo, output, 2*WIDTH: the new accumulator value of rsp_id.
REQ-012 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-013 SHALL hold one 2*WIDTH HI/LO accumulator per requester (acc0, acc1).
REQ-014 SHALL implement FSM states IDLE, RUN and DONE.
REQ-015 In IDLE, SHALL grant exactly one valid requester.
  - Both valid: grant the one not granted last (round-robin).
  - Only one valid: grant it.
  - reqN_ready = grant and IDLE, combinational; never high outside IDLE.
REQ-016 Acceptance (valid & ready at an edge) SHALL latch op, a, b and id.
  - MULTU/MADDU: go to RUN with count = ITER and partial product 0.
  - CLR: go directly to DONE with product 0.
REQ-017 In RUN, each cycle SHALL perform one shift-add step.
  - Partial += mcnd when mpr[0] = 1.
  - mcnd shifts left, mpr shifts right, count decrements.
  - Go to DONE after the step with count = 1.
REQ-018 In DONE, SHALL assert rsp_valid for exactly one cycle, then return to IDLE.
  - Accumulator write: MULTU acc = product; MADDU acc = acc + product, mod 2^(2*WIDTH); CLR acc = 0.
  - The write and rsp_hilo show the same new value in that cycle.
REQ-019 Latency, with acceptance cycle = 0:
  - MULTU/MADDU: rsp_valid in cycle ITER+1 (33 at default).
  - CLR: rsp_valid in cycle 1.
  - Next acceptance no earlier than the cycle after DONE.
REQ-020 Operand width rule: product SHALL be the full unsigned 2*WIDTH result; no truncation before accumulation.
REQ-021 Latency SHALL be fixed, with no early exit when an operand is zero.
REQ-022 Requester inputs SHALL be ignored while busy; a requester holds valid until it sees ready.
REQ-023 rsp_id and rsp_hilo SHALL be 0 whenever rsp_valid is low.
REQ-024 When both requesters are continuously valid, SHALL alternate grants 0,1,0,1 with no starvation.

Reset
REQ-025 On rst, SHALL set: state IDLE, acc0 = acc1 = 0, count 0, rsp_valid 0, busy 0, last-grant = 1 (so req0 wins first).
REQ-026 rst asserted during RUN or DONE SHALL abort the operation: no rsp_valid pulse, no accumulator update.
REQ-027 rst SHALL take priority over acceptance in the same cycle.

Structure
REQ-028 A shared package mul_pkg SHALL hold:
  - the op enum (MULTU, MADDU, CLR)
  - the FSM state enum
  - the ITER default constant
REQ-029 The iterative datapath SHALL be the sub-module mul_core.
  - Inputs: start, a, b.
  - Outputs: product, done.
  - mul_sched owns arbitration, the accumulators and the FSM.

Verification
REQ-030 Single MULTU: req0 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> rsp_valid at cycle 33, rsp_id 0, rsp_hilo 0xFFFFFFFE00000001.
REQ-031 Accumulate: req1 MULTU 3*5, then MADDU 7*11 -> responses show 15, then 92; acc0 is untouched.
REQ-032 Wrap: acc0 = 0xFFFFFFFFFFFFFFFF, then req0 MADDU 1*1 -> rsp_hilo 0.
REQ-033 Contention: req0 and req1 both held valid with MULTU 2*2 -> grants go 0,1,0,1; rsp_id alternates; each rsp_valid is 34 cycles after the previous one.
REQ-034 CLR and reset: CLR on req1 -> rsp_valid at cycle 1 with hilo 0; rst at cycle 10 of a MULTU -> no rsp_valid, busy 0 the next cycle, both accumulators 0.
